// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule definitions: S-box, FK/CK constants and
// elaboration helpers for the rounds-per-cycle parameter.
package sm4_pkg;

  typedef logic [31:0] rk_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2
  } state_t;

  localparam logic [0:3][31:0] FK = {
    32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
  };

  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[x];
  endfunction

  // Byte j of CK[i] is (4i+j)*7 mod 256, byte 0 in the top lane.
  function automatic rk_t ck(input logic [4:0] i);
    rk_t c;
    int  v;
    c = '0;
    for (int j = 0; j < 4; j++) begin
      v = (4 * int'(i) + j) * 7;
      c[31-8*j -: 8] = v[7:0];
    end
    return c;
  endfunction

  function automatic bit rpc_legal(input int r);
    return (r == 1) || (r == 2) || (r == 4) || (r == 8);
  endfunction

  function automatic int rpc_log2(input int r);
    case (r)
      2:       return 1;
      4:       return 2;
      8:       return 3;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/sm4_key_round.sv
// One combinational SM4 key-expansion round: K[i+4] = K[i] ^ L'(tau(K[i+1]^K[i+2]^K[i+3]^CK[i])).
module sm4_key_round
  import sm4_pkg::*;
(
  input  logic [31:0] k0,
  input  logic [31:0] k1,
  input  logic [31:0] k2,
  input  logic [31:0] k3,
  input  logic [31:0] ck,
  output logic [31:0] k4
);

  logic [31:0] x;
  logic [31:0] t;
  logic [31:0] l;

  assign x = k1 ^ k2 ^ k3 ^ ck;

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign t[8*gi +: 8] = sbox(x[8*gi +: 8]);
  end

  // Key-schedule linear transform: rotations by 13 and 23.
  assign l  = t ^ {t[18:0], t[31:19]} ^ {t[8:0], t[31:9]};
  assign k4 = k0 ^ l;

endmodule

// File: rtl/sm4_key_schedule_bank.sv
// Multi-slot SM4 key-expansion engine with a registered round-key read port.
// Round keys are banked by (round mod ROUNDS_PER_CYCLE) so each chained round owns one write port.
module sm4_key_schedule_bank
  import sm4_pkg::*;
#(
  parameter int NUM_SLOTS        = 4,
  parameter int SLOT_W           = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sm4_enable_in,
  input  logic                 key_valid_in,
  output logic                 key_ready_out,
  input  logic [127:0]         key_in,
  input  logic [SLOT_W-1:0]    key_slot_in,
  input  logic                 inval_in,
  input  logic [SLOT_W-1:0]    inval_slot_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [SLOT_W-1:0]    done_slot_out,
  output logic [NUM_SLOTS-1:0] slot_valid_out,
  input  logic                 rd_en_in,
  input  logic [SLOT_W-1:0]    rd_slot_in,
  input  logic [4:0]           rd_round_in,
  input  logic                 rd_dec_in,
  output logic [31:0]          rk_out,
  output logic                 rk_valid_out
);

  localparam int         R        = ROUNDS_PER_CYCLE;
  localparam int         RL       = rpc_log2(R);
  localparam int         AW       = 5 - RL;
  localparam int         MW       = SLOT_W + AW;
  localparam logic [4:0] LAST_CNT = 5'(32 - R);
  localparam logic [4:0] R_INC    = 5'(R);

  if (!rpc_legal(R)) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  state_t                state_reg, state_next;
  logic [4:0]            cnt_reg, cnt_next;
  logic [SLOT_W-1:0]     tgt_slot_reg;
  logic                  tgt_ok_reg;
  logic [31:0]           k_reg [4];
  logic [NUM_SLOTS-1:0]  slot_valid_reg, slot_valid_next;
  logic                  key_ready_reg, done_reg, rk_valid_reg;
  logic [SLOT_W-1:0]     done_slot_reg;
  logic [2:0]            lane_reg;

  logic handshake, abort_inval, last_step, done_next, wr_en, rk_valid_next;
  logic is_load, is_expand, busy;
  logic [4:0]    rd_idx;
  logic [2:0]    rd_lane;
  logic [MW-1:0] wr_addr, rd_addr;
  logic [31:0]   kw [R+4];
  logic [31:0]   bank_q [R];
  logic [31:0]   rk_sel;

  assign handshake   = key_valid_in && key_ready_reg && sm4_enable_in;
  assign abort_inval = inval_in && (inval_slot_in == tgt_slot_reg);
  assign last_step   = (cnt_reg == LAST_CNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Completion beats a same-cycle invalidate; a dropped enable beats everything.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (handshake) state_next = ST_LOAD;
      ST_LOAD:   state_next = abort_inval ? ST_IDLE : ST_EXPAND;
      ST_EXPAND: if (last_step || abort_inval) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (!sm4_enable_in) state_next = ST_IDLE;
  end

  always_comb begin
    is_load   = 1'b0;
    is_expand = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      ST_LOAD:   begin is_load = 1'b1;   busy = 1'b1; end
      ST_EXPAND: begin is_expand = 1'b1; busy = 1'b1; end
      default:   ;
    endcase
  end

  assign cnt_next  = (is_expand && state_next == ST_EXPAND) ? cnt_reg + R_INC : 5'd0;
  assign done_next = is_expand && last_step && sm4_enable_in && tgt_ok_reg;
  assign wr_en     = is_expand && sm4_enable_in && tgt_ok_reg;

  // Load clears its slot even against a same-slot invalidate; invalidate beats completion.
  always_comb begin
    slot_valid_next = slot_valid_reg;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (handshake && int'(key_slot_in) == s)          slot_valid_next[s] = 1'b0;
      else if (inval_in && int'(inval_slot_in) == s)    slot_valid_next[s] = 1'b0;
      else if (done_next && int'(tgt_slot_reg) == s)    slot_valid_next[s] = 1'b1;
    end
  end

  assign rd_idx        = rd_dec_in ? ~rd_round_in : rd_round_in;
  assign rd_lane       = 3'(rd_idx & 5'(R - 1));
  assign rd_addr       = {rd_slot_in, AW'(rd_idx >> RL)};
  assign wr_addr       = {tgt_slot_reg, AW'(cnt_reg >> RL)};
  assign rk_valid_next = rd_en_in && (int'(rd_slot_in) < NUM_SLOTS) && slot_valid_reg[rd_slot_in];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg        <= '0;
      slot_valid_reg <= '0;
      key_ready_reg  <= 1'b0;
      done_reg       <= 1'b0;
      done_slot_reg  <= '0;
      rk_valid_reg   <= 1'b0;
      lane_reg       <= '0;
      tgt_slot_reg   <= '0;
      tgt_ok_reg     <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      slot_valid_reg <= slot_valid_next;
      key_ready_reg  <= (state_next == ST_IDLE) && sm4_enable_in;
      done_reg       <= done_next;
      rk_valid_reg   <= rk_valid_next;
      if (done_next) done_slot_reg <= tgt_slot_reg;
      if (rd_en_in)  lane_reg <= rd_lane;
      if (handshake) begin
        tgt_slot_reg <= key_slot_in;
        tgt_ok_reg   <= int'(key_slot_in) < NUM_SLOTS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (handshake) begin
      for (int j = 0; j < 4; j++) k_reg[j] <= key_in[127-32*j -: 32];
    end else if (is_load) begin
      for (int j = 0; j < 4; j++) k_reg[j] <= k_reg[j] ^ FK[j];
    end else if (is_expand) begin
      for (int j = 0; j < 4; j++) k_reg[j] <= kw[R+j];
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_win
    assign kw[gi] = k_reg[gi];
  end

  for (genvar gi = 0; gi < R; gi++) begin : g_lane
    logic [31:0] ck_w;
    logic [31:0] mem [1 << MW];
    logic [31:0] q;

    assign ck_w = ck(cnt_reg + 5'(gi));

    sm4_key_round u_round (
      .k0 (kw[gi]),
      .k1 (kw[gi+1]),
      .k2 (kw[gi+2]),
      .k3 (kw[gi+3]),
      .ck (ck_w),
      .k4 (kw[gi+4])
    );

    always_ff @(posedge clk) begin
      if (wr_en)    mem[wr_addr] <= kw[gi+4];
      if (rd_en_in) q <= mem[rd_addr];
    end

    assign bank_q[gi] = q;
  end

  always_comb begin
    rk_sel = '0;
    for (int r = 0; r < R; r++) begin
      if (lane_reg == 3'(r)) rk_sel = bank_q[r];
    end
  end

  assign key_ready_out  = key_ready_reg;
  assign busy_out       = busy;
  assign done_out       = done_reg;
  assign done_slot_out  = done_slot_reg;
  assign slot_valid_out = slot_valid_reg;
  assign rk_valid_out   = rk_valid_reg;
  assign rk_out         = rk_valid_reg ? rk_sel : 32'd0;

endmodule

// File: tb/tb_sm4_key_schedule_bank.sv
// Drives an R=1 and an R=8 instance with identical stimulus and checks both
// against a word-level SM4 key-expansion model.
module tb_sm4_key_schedule_bank;

  logic         clk = 1'b0;
  logic         reset_n, sm4_enable_in, key_valid_in, inval_in, rd_en_in, rd_dec_in;
  logic [127:0] key_in;
  logic [1:0]   key_slot_in, inval_slot_in, rd_slot_in;
  logic [4:0]   rd_round_in;

  logic [1:0]        key_ready, busy, done, rk_valid;
  logic [1:0][1:0]   done_slot;
  logic [1:0][3:0]   slot_valid;
  logic [1:0][31:0]  rk;

  int n_err    = 0;
  int n_checks = 0;

  logic [31:0] m_rk [4][32];
  bit          m_valid [4];

  logic [0:255][7:0] sb_tab = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };
  logic [0:3][31:0] fk_tab = {32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

  sm4_key_schedule_bank #(.NUM_SLOTS(4), .ROUNDS_PER_CYCLE(1)) dut_r1 (
    .clk(clk), .reset_n(reset_n), .sm4_enable_in(sm4_enable_in),
    .key_valid_in(key_valid_in), .key_ready_out(key_ready[0]), .key_in(key_in),
    .key_slot_in(key_slot_in), .inval_in(inval_in), .inval_slot_in(inval_slot_in),
    .busy_out(busy[0]), .done_out(done[0]), .done_slot_out(done_slot[0]),
    .slot_valid_out(slot_valid[0]), .rd_en_in(rd_en_in), .rd_slot_in(rd_slot_in),
    .rd_round_in(rd_round_in), .rd_dec_in(rd_dec_in), .rk_out(rk[0]), .rk_valid_out(rk_valid[0])
  );

  sm4_key_schedule_bank #(.NUM_SLOTS(4), .ROUNDS_PER_CYCLE(8)) dut_r8 (
    .clk(clk), .reset_n(reset_n), .sm4_enable_in(sm4_enable_in),
    .key_valid_in(key_valid_in), .key_ready_out(key_ready[1]), .key_in(key_in),
    .key_slot_in(key_slot_in), .inval_in(inval_in), .inval_slot_in(inval_slot_in),
    .busy_out(busy[1]), .done_out(done[1]), .done_slot_out(done_slot[1]),
    .slot_valid_out(slot_valid[1]), .rd_en_in(rd_en_in), .rd_slot_in(rd_slot_in),
    .rd_round_in(rd_round_in), .rd_dec_in(rd_dec_in), .rk_out(rk[1]), .rk_valid_out(rk_valid[1])
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] t_prime(input logic [31:0] x);
    logic [31:0] b;
    for (int j = 0; j < 4; j++) b[31-8*j -: 8] = sb_tab[x[31-8*j -: 8]];
    return b ^ ((b << 13) | (b >> 19)) ^ ((b << 23) | (b >> 9));
  endfunction

  task automatic model_expand(input logic [127:0] mk, input int slot);
    logic [31:0] k [36];
    logic [31:0] ckv;
    for (int j = 0; j < 4; j++) k[j] = mk[127-32*j -: 32] ^ fk_tab[j];
    for (int i = 0; i < 32; i++) begin
      ckv = 32'd0;
      for (int j = 0; j < 4; j++) ckv = (ckv << 8) | 32'(((4 * i + j) * 7) % 256);
      k[i+4] = k[i] ^ t_prime(k[i+1] ^ k[i+2] ^ k[i+3] ^ ckv);
      m_rk[slot][i] = k[i+4];
    end
  endtask

  function automatic logic [3:0] m_vec();
    logic [3:0] v;
    for (int s = 0; s < 4; s++) v[s] = m_valid[s];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int slot, input int rnd, input bit dec,
                         input logic [31:0] kat, input bit use_kat);
    int          idx;
    bit          exp_v;
    logic [31:0] exp_rk;
    rd_en_in = 1'b1; rd_slot_in = 2'(slot); rd_round_in = 5'(rnd); rd_dec_in = dec;
    tick();
    rd_en_in = 1'b0;
    idx    = dec ? 31 - rnd : rnd;
    exp_v  = m_valid[slot];
    exp_rk = exp_v ? m_rk[slot][idx] : 32'd0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rd_valid d%0d s%0d r%0d dec%0d", d, slot, rnd, dec), 32'(rk_valid[d]), 32'(exp_v));
      chk($sformatf("rd_data d%0d s%0d r%0d dec%0d", d, slot, rnd, dec), rk[d], exp_rk);
      if (use_kat) chk($sformatf("kat d%0d r%0d dec%0d", d, rnd, dec), rk[d], kat);
    end
    $display("read slot=%0d round=%0d dec=%0d -> r1=%h/%0d r8=%h/%0d", slot, rnd, dec,
             rk[0], rk_valid[0], rk[1], rk_valid[1]);
  endtask

  task automatic load_key(input logic [127:0] key, input int slot, input bit mid_read, input bit inval_same);
    int dc [2];
    for (int d = 0; d < 2; d++) chk($sformatf("ready_pre d%0d", d), 32'(key_ready[d]), 32'd1);
    key_valid_in = 1'b1; key_in = key; key_slot_in = 2'(slot);
    if (inval_same) begin inval_in = 1'b1; inval_slot_in = 2'(slot); end
    tick();
    key_valid_in = 1'b0; inval_in = 1'b0;
    m_valid[slot] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy_hs d%0d", d), 32'(busy[d]), 32'd1);
      chk($sformatf("valid_clr d%0d", d), 32'(slot_valid[d][slot]), 32'd0);
    end
    dc[0] = 0; dc[1] = 0;
    for (int c = 1; c <= 40; c++) begin
      if (mid_read && c == 2) begin
        rd_en_in = 1'b1; rd_slot_in = 2'(slot); rd_round_in = 5'(c); rd_dec_in = 1'b0;
      end
      tick();
      rd_en_in = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (mid_read && c == 2) chk($sformatf("mid_rd_valid d%0d", d), 32'(rk_valid[d]), 32'd0);
        if (done[d]) begin
          dc[d] = c;
          chk($sformatf("done_slot d%0d", d), 32'(done_slot[d]), 32'(slot));
          chk($sformatf("valid_set d%0d", d), 32'(slot_valid[d][slot]), 32'd1);
        end else if (dc[d] == 0) begin
          chk($sformatf("valid_wait d%0d c%0d", d, c), 32'(slot_valid[d][slot]), 32'd0);
        end
      end
    end
    chk("done_cycle r1", 32'(dc[0]), 32'd33);
    chk("done_cycle r8", 32'(dc[1]), 32'd5);
    model_expand(key, slot);
    m_valid[slot] = 1'b1;
    $display("load slot=%0d key=%h done_cycle r1=%0d r8=%0d", slot, key, dc[0], dc[1]);
  endtask

  // Starts a load and kills it two edges into expansion, by invalidate or by enable.
  task automatic abort_load(input logic [127:0] key, input int slot, input bit by_inval);
    bit seen [2];
    key_valid_in = 1'b1; key_in = key; key_slot_in = 2'(slot);
    tick();
    key_valid_in = 1'b0;
    m_valid[slot] = 1'b0;
    tick();
    tick();
    if (by_inval) begin inval_in = 1'b1; inval_slot_in = 2'(slot); end
    else sm4_enable_in = 1'b0;
    tick();
    inval_in = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("abort_busy d%0d", d), 32'(busy[d]), 32'd0);
      chk($sformatf("abort_ready d%0d", d), 32'(key_ready[d]), 32'(by_inval));
      seen[d] = 1'b0;
    end
    for (int c = 0; c < 40; c++) begin
      tick();
      for (int d = 0; d < 2; d++) seen[d] = seen[d] | done[d];
    end
    if (!by_inval) begin
      sm4_enable_in = 1'b1;
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("abort_no_done d%0d", d), 32'(seen[d]), 32'd0);
      chk($sformatf("abort_valid d%0d", d), 32'(slot_valid[d][slot]), 32'd0);
      chk($sformatf("abort_ready_back d%0d", d), 32'(key_ready[d]), 32'd1);
    end
    $display("abort slot=%0d by_inval=%0d slot_valid r1=%b r8=%b", slot, by_inval, slot_valid[0], slot_valid[1]);
  endtask

  logic [127:0] kat_key;

  initial begin
    reset_n = 1'b0; sm4_enable_in = 1'b1; key_valid_in = 1'b0; key_in = '0; key_slot_in = '0;
    inval_in = 1'b0; inval_slot_in = '0; rd_en_in = 1'b0; rd_slot_in = '0; rd_round_in = '0; rd_dec_in = 1'b0;
    for (int s = 0; s < 4; s++) m_valid[s] = 1'b0;
    kat_key = 128'h0123456789ABCDEFFEDCBA9876543210;

    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready d%0d", d), 32'(key_ready[d]), 32'd0);
      chk($sformatf("rst_busy d%0d", d), 32'(busy[d]), 32'd0);
      chk($sformatf("rst_done d%0d", d), 32'({done_slot[d], done[d]}), 32'd0);
      chk($sformatf("rst_slot_valid d%0d", d), 32'(slot_valid[d]), 32'd0);
      chk($sformatf("rst_rd d%0d", d), rk[d] | 32'(rk_valid[d]), 32'd0);
    end
    $display("reset checked");
    reset_n = 1'b1;
    tick();

    load_key(kat_key, 0, 1'b0, 1'b0);
    do_read(0, 0, 1'b0, 32'hF12186F9, 1'b1);
    do_read(0, 1, 1'b0, 32'h41662B61, 1'b1);
    do_read(0, 31, 1'b0, 32'h9124A012, 1'b1);
    do_read(0, 0, 1'b1, 32'h9124A012, 1'b1);

    load_key(kat_key, 3, 1'b0, 1'b0);
    for (int r = 0; r < 32; r++) do_read(3, r, 1'b0, 32'd0, 1'b0);

    abort_load({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0);
    do_read(0, 5, 1'b0, 32'd0, 1'b0);

    load_key({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0, 1'b0);
    do_read(1, 7, 1'b0, 32'd0, 1'b0);
    load_key({$urandom, $urandom, $urandom, $urandom}, 1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) do_read(1, int'($urandom_range(0, 31)), 1'($urandom), 32'd0, 1'b0);

    load_key({$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, 1'b0);
    load_key({$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, 1'b1);
    inval_in = 1'b1; inval_slot_in = 2'd3;
    tick();
    inval_in = 1'b0;
    m_valid[3] = 1'b0;
    for (int d = 0; d < 2; d++) chk($sformatf("inval_only d%0d", d), 32'(slot_valid[d]), 32'(m_vec()));
    $display("inval slot=3 slot_valid r1=%b r8=%b", slot_valid[0], slot_valid[1]);
    do_read(3, 9, 1'b0, 32'd0, 1'b0);

    abort_load({$urandom, $urandom, $urandom, $urandom}, 1, 1'b1);
    for (int d = 0; d < 2; d++) chk($sformatf("post_abort_vec d%0d", d), 32'(slot_valid[d]), 32'(m_vec()));

    for (int i = 0; i < 40; i++)
      do_read(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), 1'($urandom), 32'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
